// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer for the 64-entry data memory window.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead of fixed port-0 priority.
module data_mem_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MEM_BASE  = 64,
    parameter int unsigned MEM_LIMIT = 127
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_i,
    input  logic [1:0]          we_i,
    input  logic [2*ADDR_W-1:0] addr_i,
    input  logic [2*DATA_W-1:0] wdata_i,
    output logic [1:0]          gnt_o,
    output logic [1:0]          rsp_valid_o,
    output logic                rsp_err_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic                mem_we_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(MEM_BASE);
    localparam logic [ADDR_W-1:0] LIMIT_A = ADDR_W'(MEM_LIMIT);

    state_t              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                owner_q, owner_d;
    logic                inwin_q, inwin_d;
    logic                wr_q, wr_d;

    logic                win;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;
    logic                sel_inwin;

`ifdef ARB_ROUND_ROBIN_EN
    logic                last_q, last_d;

    // On contention the port not granted last wins; otherwise the sole requester.
    always_comb begin
        if (req_i == 2'b11) win = ~last_q;
        else                win = req_i[1];
    end
`else
    always_comb win = ~req_i[0];
`endif

    always_comb begin
        sel_addr  = win ? addr_i[2*ADDR_W-1:ADDR_W]  : addr_i[ADDR_W-1:0];
        sel_wdata = win ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
        sel_we    = win ? we_i[1] : we_i[0];
        sel_inwin = (sel_addr >= BASE_A) && (sel_addr <= LIMIT_A);
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rdata_d     = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = owner_q;
        inwin_d     = inwin_q;
        wr_d        = wr_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d      = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d       = win ? 2'b10 : 2'b01;
                    owner_d     = win;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    wr_d        = sel_we;
                    inwin_d     = sel_inwin;
                    mem_we_d    = sel_we & sel_inwin;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d      = win;
`endif
                    state_d     = ACCESS;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                rdata_d     = (inwin_q && !wr_q) ? mem_rdata_i : '0;
                rsp_err_d   = ~inwin_q;
                rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            owner_q     <= 1'b0;
            inwin_q     <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            owner_q     <= owner_d;
            inwin_q     <= inwin_d;
            wr_q        <= wr_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`endif

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rdata_o     = rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 64x8 synchronous memory.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [15:0] addr_i;
    logic [15:0] wdata_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rsp_valid_o;
    logic        rsp_err_o;
    logic [7:0]  rdata_o;
    logic [7:0]  mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_we_o;
    logic [7:0]  mem_rdata_i;
    logic        busy_o;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    data_mem_arbiter #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .MEM_BASE  (64),
        .MEM_LIMIT (127)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_err_o   (rsp_err_o),
        .rdata_o     (rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_we_o    (mem_we_o),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents start as 0x80 + offset, so addr 64 -> 0x80, 100 -> 0xA4, 127 -> 0xBF.
    logic [7:0] mem [64];
    logic       mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h80 + 8'(i);
            mem_init_done <= 1'b1;
            mem_rdata_i   <= 8'h00;
        end else begin
            if (mem_we_o && mem_addr_o[7:6] == 2'b01) mem[mem_addr_o[5:0]] <= mem_wdata_o;
            mem_rdata_i <= (mem_addr_o[7:6] == 2'b01) ? mem[mem_addr_o[5:0]] : 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge and follow it through grant, access and response.
    task automatic do_op(input int unsigned p, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic exp_we, input logic exp_err,
                         input logic [7:0] exp_rd, input logic hold);
        logic [1:0] pm;
        pm = (p == 0) ? 2'b01 : 2'b10;
        req_i   = pm;
        we_i    = {w, w};
        addr_i  = {a, a};
        wdata_i = {d, d};
        @(negedge clk);
        chk("op_gnt", 16'(gnt_o), 16'(pm));
        chk("op_mem_we", 16'(mem_we_o), 16'(exp_we));
        chk("op_mem_addr", 16'(mem_addr_o), 16'(a));
        chk("op_busy_e0", 16'(busy_o), 16'd1);
        chk("op_rsp_e0", 16'(rsp_valid_o), 16'd0);
        if (!hold) req_i = 2'b00;
        @(negedge clk);
        chk("op_gnt_e1", 16'(gnt_o), 16'd0);
        chk("op_mem_we_e1", 16'(mem_we_o), 16'd0);
        chk("op_busy_e1", 16'(busy_o), 16'd1);
        @(negedge clk);
        chk("op_rsp_valid", 16'(rsp_valid_o), 16'(pm));
        chk("op_rsp_err", 16'(rsp_err_o), 16'(exp_err));
        chk("op_rdata", 16'(rdata_o), 16'(exp_rd));
        chk("op_busy_e2", 16'(busy_o), 16'd0);
        chk("op_gnt_e2", 16'(gnt_o), 16'd0);
    endtask

    logic [1:0] exp_g [3];
    logic [7:0] exp_d [3];

    initial begin
        rst_n   = 1'b0;
        req_i   = 2'b00;
        we_i    = 2'b00;
        addr_i  = '0;
        wdata_i = '0;
        repeat (3) @(negedge clk);

        chk("rst_gnt", 16'(gnt_o), 16'd0);
        chk("rst_rsp_valid", 16'(rsp_valid_o), 16'd0);
        chk("rst_rsp_err", 16'(rsp_err_o), 16'd0);
        chk("rst_rdata", 16'(rdata_o), 16'd0);
        chk("rst_mem_addr", 16'(mem_addr_o), 16'd0);
        chk("rst_mem_wdata", 16'(mem_wdata_o), 16'd0);
        chk("rst_mem_we", 16'(mem_we_o), 16'd0);
        chk("rst_busy", 16'(busy_o), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req_busy", 16'(busy_o), 16'd0);

        // Simultaneous reads: port0 addr 64, port1 addr 127, held through the third grant.
`ifdef ARB_ROUND_ROBIN_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        exp_d[0] = 8'h80; exp_d[1] = 8'hBF; exp_d[2] = 8'h80;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01;
        exp_d[0] = 8'h80; exp_d[1] = 8'h80; exp_d[2] = 8'h80;
`endif
        req_i   = 2'b11;
        we_i    = 2'b00;
        addr_i  = {8'd127, 8'd64};
        wdata_i = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("arb_gnt", 16'(gnt_o), 16'(exp_g[k]));
            if (k == 2) req_i = 2'b00;
            @(negedge clk);
            chk("arb_idle_gnt", 16'(gnt_o), 16'd0);
            @(negedge clk);
            chk("arb_rsp_valid", 16'(rsp_valid_o), 16'(exp_g[k]));
            chk("arb_rdata", 16'(rdata_o), 16'(exp_d[k]));
        end
        @(negedge clk);
        chk("arb_released", 16'(gnt_o), 16'd0);

        // Port 0 write 0xA5 to 70, then read it back.
        do_op(0, 1'b1, 8'd70, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
        do_op(0, 1'b0, 8'd70, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0);

        // Out-of-window write from port 1, then addr 64 still holds its original value.
        do_op(1, 1'b1, 8'd20, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0);
        do_op(1, 1'b0, 8'd64, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0);
        do_op(0, 1'b1, 8'd128, 8'h11, 1'b0, 1'b1, 8'h00, 1'b0);
        do_op(0, 1'b0, 8'd63, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);

        // Port 1 holds a read of 127 continuously: regranted every 3 cycles.
        do_op(1, 1'b0, 8'd127, 8'h00, 1'b0, 1'b0, 8'hBF, 1'b1);
        do_op(1, 1'b0, 8'd127, 8'h00, 1'b0, 1'b0, 8'hBF, 1'b1);
        do_op(1, 1'b0, 8'd127, 8'h00, 1'b0, 1'b0, 8'hBF, 1'b0);

        // Reset between grant and the ACCESS edge abandons the write.
        req_i   = 2'b01;
        we_i    = 2'b11;
        addr_i  = {8'd100, 8'd100};
        wdata_i = {8'h3C, 8'h3C};
        @(posedge clk);
        #1;
        chk("mid_gnt", 16'(gnt_o), 16'd1);
        chk("mid_mem_we", 16'(mem_we_o), 16'd1);
        #1;
        rst_n = 1'b0;
        req_i = 2'b00;
        #1;
        chk("mid_rst_gnt", 16'(gnt_o), 16'd0);
        chk("mid_rst_mem_we", 16'(mem_we_o), 16'd0);
        chk("mid_rst_mem_addr", 16'(mem_addr_o), 16'd0);
        chk("mid_rst_mem_wdata", 16'(mem_wdata_o), 16'd0);
        chk("mid_rst_busy", 16'(busy_o), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 16'(rsp_valid_o), 16'd0);
        end
        do_op(0, 1'b0, 8'd100, 8'h00, 1'b0, 1'b0, 8'hA4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
